// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-write scoreboard.
//   - Up to two write ports (NWP), two combinational read ports.
//   - Register 0 is hard-wired to zero and can never be marked busy.
//   - One busy bit per register: alloc sets it, any write to it clears it,
//     and a same-cycle alloc wins over the clearing write.
//   - Optional macro REGFILE_BYPASS_EN: reads observe same-cycle write data
//     (port 1 first) and see busy cleared unless re-allocated that cycle.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NWP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en0,
  input  logic                     en1,
  input  logic [$clog2(NREG)-1:0]  rd_addr0,
  input  logic [$clog2(NREG)-1:0]  rd_addr1,
  input  logic [XLEN-1:0]          data_in0,
  input  logic [XLEN-1:0]          data_in1,
  input  logic [$clog2(NREG)-1:0]  rs1_addr,
  input  logic [$clog2(NREG)-1:0]  rs2_addr,
  output logic [XLEN-1:0]          op_a,
  output logic [XLEN-1:0]          op_b,
  input  logic                     alloc_en,
  input  logic [$clog2(NREG)-1:0]  alloc_addr,
  output logic                     busy_a,
  output logic                     busy_b
);

  localparam int AW = $clog2(NREG);

  // Port 1 only exists in the two-write-port configuration.
  logic we0;
  logic we1;
  assign we0 = en0;
  assign we1 = (NWP >= 2) && en1;

  // Flattened view of the storage and scoreboard for the read muxes.
  logic [XLEN-1:0] rf_data [NREG];
  logic [NREG-1:0] busy_vec;

  // One storage slot plus busy bit per architectural register.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_data[gi]  = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_slot
        localparam logic [AW-1:0] IDX = AW'(gi);

        logic            hit0;
        logic            hit1;
        logic            hit_alloc;
        logic [XLEN-1:0] data_reg;
        logic [XLEN-1:0] data_next;
        logic            busy_reg;
        logic            busy_next;

        assign hit0      = we0 && (rd_addr0 == IDX);
        assign hit1      = we1 && (rd_addr1 == IDX);
        assign hit_alloc = alloc_en && (alloc_addr == IDX);

        // Next data: port 1 has priority when both ports target this slot.
        always_comb begin
          data_next = data_reg;
          if (hit1) begin
            data_next = data_in1;
          end else if (hit0) begin
            data_next = data_in0;
          end
        end

        // Next busy: a new producer (alloc) outranks the completing write.
        always_comb begin
          busy_next = busy_reg;
          if (hit_alloc) begin
            busy_next = 1'b1;
          end else if (hit0 || hit1) begin
            busy_next = 1'b0;
          end
        end

        // Commit data and busy state; reset clears everything and masks writes.
        always_ff @(posedge clk) begin
          if (rst) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            data_reg <= data_next;
            busy_reg <= busy_next;
          end
        end

        assign rf_data[gi]  = data_reg;
        assign busy_vec[gi] = busy_reg;
      end
    end
  endgenerate

  // Two identical read ports; index 0 drives op_a/busy_a, index 1 op_b/busy_b.
  logic [AW-1:0]   rs_addr  [2];
  logic [XLEN-1:0] rd_data  [2];
  logic            rd_busy  [2];

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] stored_data;
      logic            stored_busy;

      assign stored_data = rf_data[rs_addr[gi]];
      assign stored_busy = busy_vec[rs_addr[gi]];

`ifdef REGFILE_BYPASS_EN
      logic            nonzero;
      logic            byp0;
      logic            byp1;
      logic            byp_alloc;
      logic [XLEN-1:0] data_out;
      logic            busy_out;

      assign nonzero   = (rs_addr[gi] != '0);
      assign byp0      = nonzero && we0 && (rd_addr0 == rs_addr[gi]);
      assign byp1      = nonzero && we1 && (rd_addr1 == rs_addr[gi]);
      assign byp_alloc = nonzero && alloc_en && (alloc_addr == rs_addr[gi]);

      // Forward in-flight write data; busy follows what the edge will leave.
      always_comb begin
        data_out = stored_data;
        busy_out = stored_busy;
        if (byp1) begin
          data_out = data_in1;
          busy_out = byp_alloc;
        end else if (byp0) begin
          data_out = data_in0;
          busy_out = byp_alloc;
        end
      end

      assign rd_data[gi] = data_out;
      assign rd_busy[gi] = busy_out;
`else
      assign rd_data[gi] = stored_data;
      assign rd_busy[gi] = stored_busy;
`endif
    end
  endgenerate

  assign op_a   = rd_data[0];
  assign op_b   = rd_data[1];
  assign busy_a = rd_busy[0];
  assign busy_b = rd_busy[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: table-driven vectors checked through a scoreboard
// queue, a reset sweep, a model-checked random phase, and a reduced-parameter
// instance (XLEN=16, NREG=8, NWP=1).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance signals
  logic        rst = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0, alloc_en = 1'b0;
  logic [4:0]  rd_addr0 = '0, rd_addr1 = '0, alloc_addr = '0;
  logic [31:0] data_in0 = '0, data_in1 = '0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic [31:0] op_a, op_b;
  logic        busy_a, busy_b;

  regfile_mp dut (
    .clk(clk), .rst(rst), .en0(en0), .en1(en1),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .data_in0(data_in0), .data_in1(data_in1),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .op_a(op_a), .op_b(op_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  // Reduced instance signals
  logic        s_rst = 1'b1;
  logic        s_en0 = 1'b0, s_en1 = 1'b0, s_alloc_en = 1'b0;
  logic [2:0]  s_rd_addr0 = '0, s_rd_addr1 = '0, s_alloc_addr = '0;
  logic [15:0] s_data_in0 = '0, s_data_in1 = '0;
  logic [2:0]  s_rs1_addr = '0, s_rs2_addr = '0;
  logic [15:0] s_op_a, s_op_b;
  logic        s_busy_a, s_busy_b;

  regfile_mp #(.XLEN(16), .NREG(8), .NWP(1)) dut_s (
    .clk(clk), .rst(s_rst), .en0(s_en0), .en1(s_en1),
    .rd_addr0(s_rd_addr0), .rd_addr1(s_rd_addr1),
    .data_in0(s_data_in0), .data_in1(s_data_in1),
    .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
    .op_a(s_op_a), .op_b(s_op_b),
    .alloc_en(s_alloc_en), .alloc_addr(s_alloc_addr),
    .busy_a(s_busy_a), .busy_b(s_busy_b)
  );

  typedef struct {
    bit          rst;
    bit          en0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          en1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          al;
    logic [4:0]  aa;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          eba;
    bit          ebb;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          ba;
    bit          bb;
    string       tag;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state for the random phase
  logic [31:0] mdl_mem [32];
  bit          mdl_busy [32];

  function automatic vec_t v(bit r, bit e0, logic [4:0] a0, logic [31:0] d0,
                             bit e1, logic [4:0] a1, logic [31:0] d1,
                             bit al, logic [4:0] aa, logic [4:0] rs1, logic [4:0] rs2,
                             logic [31:0] ea, logic [31:0] eb, bit eba, bit ebb);
    vec_t t;
    t.rst = r;   t.en0 = e0; t.a0 = a0; t.d0 = d0;
    t.en1 = e1;  t.a1 = a1;  t.d1 = d1;
    t.al = al;   t.aa = aa;  t.rs1 = rs1; t.rs2 = rs2;
    t.ea = ea;   t.eb = eb;  t.eba = eba; t.ebb = ebb;
    return t;
  endfunction

  task automatic chk(string nm, int id, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s #%0d got %h want %h", nm, id, got, want);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue what the
  // combinational outputs must show before the next edge.
  task automatic drive(vec_t t, string tag, int id);
    exp_t e;
    @(posedge clk);
    #1;
    rst = t.rst; en0 = t.en0; rd_addr0 = t.a0; data_in0 = t.d0;
    en1 = t.en1; rd_addr1 = t.a1; data_in1 = t.d1;
    alloc_en = t.al; alloc_addr = t.aa; rs1_addr = t.rs1; rs2_addr = t.rs2;
    e.a = t.ea; e.b = t.eb; e.ba = t.eba; e.bb = t.ebb; e.tag = tag; e.id = id;
    sb.push_back(e);
    $display("drive %s #%0d rst=%0d w0=%0d:%0d=%h w1=%0d:%0d=%h al=%0d:%0d rs=%0d,%0d",
             tag, id, t.rst, t.en0, t.a0, t.d0, t.en1, t.a1, t.d1, t.al, t.aa, t.rs1, t.rs2);
  endtask

  // Output checker: pops one expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, " op_a"}, e.id, op_a, e.a);
      chk({e.tag, " op_b"}, e.id, op_b, e.b);
      chk({e.tag, " busy_a"}, e.id, {31'b0, busy_a}, {31'b0, e.ba});
      chk({e.tag, " busy_b"}, e.id, {31'b0, busy_b}, {31'b0, e.bb});
    end
  end

  // Expected read value for the model, including same-cycle forwarding.
  function automatic logic [32:0] model_read(vec_t t, logic [4:0] ra);
    logic [31:0] d;
    bit          b;
    d = mdl_mem[ra];
    b = mdl_busy[ra];
    if (BYP && ra != 5'd0) begin
      if (t.en1 && t.a1 == ra) begin
        d = t.d1; b = t.al && (t.aa == ra);
      end else if (t.en0 && t.a0 == ra) begin
        d = t.d0; b = t.al && (t.aa == ra);
      end
    end
    return {b, d};
  endfunction

  task automatic model_commit(vec_t t);
    for (int i = 0; i < 32; i++) begin
      if (t.rst || i == 0) begin
        mdl_mem[i] = '0;
        mdl_busy[i] = 1'b0;
      end else begin
        if (t.en1 && t.a1 == 5'(i)) mdl_mem[i] = t.d1;
        else if (t.en0 && t.a0 == 5'(i)) mdl_mem[i] = t.d0;
        if (t.al && t.aa == 5'(i)) mdl_busy[i] = 1'b1;
        else if ((t.en0 && t.a0 == 5'(i)) || (t.en1 && t.a1 == 5'(i))) mdl_busy[i] = 1'b0;
      end
    end
  endtask

  vec_t tbl [21];

  initial begin
    vec_t        t;
    logic [32:0] ra, rb;

    // Vectors: outputs are those seen in the same cycle, before the edge.
    tbl[0]  = v(1, 1, 4, 32'h55, 0, 0, 0, 1, 4, 4, 9, BYP ? 32'h55 : 32'h0, 0, BYP, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 5, 6,
                BYP ? 32'h22222222 : 32'h0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'h22222222, 32'h22222222, 0, 0);
    tbl[4]  = v(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h22222222, 0, 0);
    tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0);
    tbl[7]  = v(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 1, 7, 7, 5,
                BYP ? 32'hA5A5A5A5 : 32'h0, 32'h22222222, 1, 0);
    tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1);
    tbl[9]  = v(0, 0, 0, 0, 1, 8, 32'h8, 1, 7, 7, 8, 32'hA5A5A5A5, BYP ? 32'h8 : 32'h0, 1, 0);
    tbl[10] = v(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 8,
                BYP ? 32'h77 : 32'hA5A5A5A5, 32'h8, !BYP, 0);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h77, 32'h77, 0, 0);
    tbl[12] = v(0, 1, 8, 32'h88, 0, 0, 0, 1, 9, 8, 9, BYP ? 32'h88 : 32'h8, 0, 0, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 9, 32'h88, 0, 0, 1);
    tbl[14] = v(0, 1, 3, 32'h1, 0, 0, 0, 0, 0, 3, 9, BYP ? 32'h1 : 32'h0, 0, 0, 1);
    tbl[15] = v(0, 1, 3, 32'h2, 0, 0, 0, 0, 0, 9, 3, 0, BYP ? 32'h2 : 32'h1, 1, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'h2, 32'h2, 0, 0);
    tbl[17] = v(0, 1, 9, 32'h90, 1, 9, 32'h91, 0, 0, 9, 9,
                BYP ? 32'h91 : 32'h0, BYP ? 32'h91 : 32'h0, !BYP, !BYP);
    tbl[18] = v(1, 1, 11, 32'hBB, 0, 0, 0, 1, 10, 9, 3, 32'h91, 32'h2, 0, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0, 0, 0, 0);
    tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0);

    // Initial reset, then sweep every address on both read ports.
    repeat (2) @(posedge clk);
    for (int a = 0; a < 32; a++) begin
      drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0, 0), "sweep", a);
    end

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i], "vec", i);
    end

    // Random phase against the reference model; vec 18 left state all-zero.
    for (int i = 0; i < 32; i++) begin
      mdl_mem[i] = '0;
      mdl_busy[i] = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      t = v($urandom_range(0, 29) == 0, 1'($urandom), 5'($urandom_range(0, 15)), $urandom,
            1'($urandom), 5'($urandom_range(0, 15)), $urandom,
            1'($urandom), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 0, 0, 0, 0);
      ra = model_read(t, t.rs1);
      rb = model_read(t, t.rs2);
      t.ea = ra[31:0]; t.ebb = rb[32];
      t.eb = rb[31:0]; t.eba = ra[32];
      drive(t, "rand", i);
      model_commit(t);
    end

    // Let the checker drain, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    @(posedge clk);
    #1;
    en0 = 0; en1 = 0; alloc_en = 0;

    // Reduced instance: single write port, 16-bit data, 8 registers.
    @(posedge clk); #1; s_rst = 1'b0;
    s_en1 = 1; s_rd_addr1 = 3'd6; s_data_in1 = 16'h1234; s_rs1_addr = 3'd6; s_rs2_addr = 3'd6;
    @(negedge clk);
    chk("small en1 same-cycle", 0, {16'h0, s_op_a}, 32'h0);
    @(posedge clk); #1;
    s_en1 = 0;
    @(negedge clk);
    chk("small en1 ignored", 1, {16'h0, s_op_a}, 32'h0);
    @(posedge clk); #1;
    s_en0 = 1; s_rd_addr0 = 3'd7; s_data_in0 = 16'hFFFF;
    s_en1 = 1; s_rd_addr1 = 3'd7; s_data_in1 = 16'h1111;
    s_alloc_en = 1; s_alloc_addr = 3'd5; s_rs1_addr = 3'd7; s_rs2_addr = 3'd5;
    @(negedge clk);
    chk("small w7 same-cycle", 2, {16'h0, s_op_a}, BYP ? 32'hFFFF : 32'h0);
    @(posedge clk); #1;
    s_en0 = 0; s_en1 = 0; s_alloc_en = 0;
    @(negedge clk);
    chk("small w7 readback", 3, {16'h0, s_op_a}, 32'hFFFF);
    chk("small busy5", 4, {31'b0, s_busy_b}, 32'h1);
    chk("small busy7", 5, {31'b0, s_busy_a}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, 32, register data width (8..64).
REQ-002 SHALL have parameter NREG, 32, register count (power of two, 2..64); AW = clog2(NREG) derived, not overridable.
REQ-003 SHALL have parameter NWP, 2, number of active write ports (1 or 2); with NWP=1, en1/rd_addr1/data_in1 ignored.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports en0/en1, input, 1 each, write enable, port 0/1.
REQ-007 SHALL have ports rd_addr0/rd_addr1, input, AW each, write address.
REQ-008 SHALL have ports data_in0/data_in1, input, XLEN each, write data.
REQ-009 SHALL have ports rs1_addr/rs2_addr, input, AW each, read addresses.
REQ-010 SHALL have ports op_a/op_b, output, XLEN each, read data.
REQ-011 SHALL have ports alloc_en (input, 1) and alloc_addr (input, AW), marking a register pending a future write.
REQ-012 SHALL have ports busy_a/busy_b, output, 1 each, scoreboard pending status of rs1_addr/rs2_addr.

Function
REQ-013 Register 0 SHALL read as zero; writes and allocs to address 0 SHALL be discarded; busy for address 0 SHALL be 0.
REQ-014 Writes SHALL commit on the rising clk edge when enN=1; one-cycle write latency.
REQ-015 Both ports writing the same nonzero address in one cycle: port 1 data SHALL win.
REQ-016 Reads SHALL be combinational from rsX_addr; zero read latency.
REQ-017 Scoreboard: one busy bit per register; alloc_en sets busy[alloc_addr] at the edge; any enN write to an address clears its busy bit at the edge.
REQ-018 Same-cycle alloc and write to the same address: set SHALL win (new producer pending).
REQ-019 Alloc to an already-busy register SHALL leave it busy (no counting, no error).
REQ-020 Write to a non-busy register SHALL be legal and update data; busy stays 0.
REQ-021 Two read ports SHALL be independent; rs1_addr==rs2_addr returns identical data and busy.

Reset
REQ-022 With rst=1 at a rising edge, all registers SHALL become 0 and all busy bits 0, overriding writes and allocs that cycle.
REQ-023 After reset, op_a/op_b SHALL read 0 and busy_a/busy_b 0 for every address until written/allocated.
REQ-024 Reset asserted mid-sequence SHALL discard pending busy state; no write in that cycle commits.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN: when defined, a read matching an active same-cycle write address (nonzero) SHALL return that write data (port 1 priority per REQ-015), and busy_X SHALL read 0 unless alloc to that address is also active that cycle.
REQ-026 Without REGFILE_BYPASS_EN, reads SHALL return stored (pre-edge) value and busy_X the stored busy bit.
REQ-027 During rst=1, bypass SHALL still apply combinationally; stored state is governed by REQ-022.

Verification
REQ-028 Reset: rst=1 one edge, then sweep rs1_addr 0..NREG-1 -> op_a=0, busy_a=0 for all.
REQ-029 Collision: en0=en1=1, rd_addr0=rd_addr1=5, data_in0=0x11111111, data_in1=0x22222222 -> next cycle op_a(rs1=5)=0x22222222.
REQ-030 x0: en0=1, rd_addr0=0, data_in0=0xDEADBEEF; alloc_en=1, alloc_addr=0 -> op_a(rs1=0)=0, busy_a=0.
REQ-031 Scoreboard: alloc 7 -> busy_a(rs1=7)=1; write 7=0xA5A5A5A5 with alloc 7 same cycle -> busy stays 1, data updated; later write 7 alone -> busy 0.
REQ-032 Bypass: reg 3=0x1; same cycle en0=1, rd_addr0=3, data_in0=0x2, rs2_addr=3 -> op_b=0x2 with REGFILE_BYPASS_EN, 0x1 without; op_b=0x2 next cycle both builds.
REQ-033 Parameters: XLEN=16, NREG=8, NWP=1 -> en1 writes ignored; write 7=0xFFFF via port 0 reads back 0xFFFF.
